// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - main-memory controller: critical-word-first L2 line refills and single-word stores
module mem_burst_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4,
    parameter int BURST_LEN   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic [2:0]  beat,
    output logic        done,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] LAT_START = CW'(LATENCY - 1);
    localparam logic [2:0]    LAST_BEAT = 3'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, WAIT, BURST, WRITE} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [AW-4:0] base, base_d;
    logic [2:0]    start, start_d;
    logic [2:0]    idx, idx_d;
    logic          rvalid_d, done_d, emit;
    logic [31:0]   rdata_d;
    logic [2:0]    beat_d;
    logic [2:0]    word_sel;
    logic          accept;
    logic          unused_addr_bits;

    logic [31:0] mem [DEPTH_WORDS];

    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
    assign accept    = (state == IDLE) && req_valid;
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign word_sel  = start + idx;

    // Stores commit on the acceptance edge, so a later reset cannot lose them.
    always_ff @(posedge clk) begin
        if (rst && accept && req_write)
            mem[req_addr[AW+1:2]] <= req_wdata;
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        base_d   = base;
        start_d  = start;
        idx_d    = idx;
        emit     = 1'b0;
        rvalid_d = 1'b0;
        rdata_d  = '0;
        beat_d   = '0;
        done_d   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    base_d  = req_addr[AW+1:5];
                    start_d = req_addr[4:2];
                    idx_d   = '0;
                    cnt_d   = LAT_START;
                    state_d = req_write ? WRITE : WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    emit    = 1'b1;
                    state_d = BURST;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            BURST: begin
                // done is raised together with the last beat, so seeing it here ends the line
                if (done) state_d = IDLE;
                else      emit    = 1'b1;
            end
            WRITE: begin
                if (done)              state_d = IDLE;
                else if (cnt == '0)    done_d  = 1'b1;
                else                   cnt_d   = cnt - CW'(1);
            end
            default: state_d = IDLE;
        endcase
        if (emit) begin
            rvalid_d = 1'b1;
            beat_d   = word_sel;
            rdata_d  = mem[{base, word_sel}];
            done_d   = (idx == LAST_BEAT);
            idx_d    = idx + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            base   <= '0;
            start  <= '0;
            idx    <= '0;
            rvalid <= 1'b0;
            rdata  <= '0;
            beat   <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            base   <= base_d;
            start  <= start_d;
            idx    <= idx_d;
            rvalid <= rvalid_d;
            rdata  <= rdata_d;
            beat   <= beat_d;
            done   <= done_d;
        end
    end
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb/tb_mem_burst_ctrl.sv - self-checking bench for mem_burst_ctrl
module tb_mem_burst_ctrl;
    localparam int L  = 4;
    localparam int DW = 1024;

    typedef struct {
        bit          w;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  exp_beat;
        logic [31:0] exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rvalid, done, busy;
    logic [31:0] rdata;
    logic [2:0]  beat;

    int          total = 0;
    int          bad = 0;
    logic [31:0] ref_mem [DW];
    bit          ref_known [DW];
    vec_t        vecs [15];
    int          accepts, acc_j, busy_low;
    logic [2:0]  fb;
    logic [31:0] fd;

    mem_burst_ctrl #(.DEPTH_WORDS(DW), .LATENCY(L), .BURST_LEN(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rvalid(rvalid), .rdata(rdata), .beat(beat), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 32'(DW));
    endfunction

    // j counts samples taken after the acceptance edge (j=0 follows that edge)
    task automatic check_cycle(input string tag, input bit w, input int j, input logic [31:0] a);
        int st, wi, e_beat, n;
        bit e_rv, e_done, e_busy, ok;
        logic [31:0] e_data;
        n      = w ? L + 1 : L + 8;
        st     = widx(a) % 8;
        e_rv   = !w && j >= L && j <= L + 7;
        e_beat = e_rv ? (st + j - L) % 8 : 0;
        wi     = (widx(a) / 8) * 8 + e_beat;
        e_data = e_rv ? ref_mem[wi] : 32'd0;
        e_done = w ? (j == L) : (j == L + 7);
        e_busy = j < n;
        ok = (req_ready == !e_busy) && (busy == e_busy) && (rvalid == e_rv) &&
             (done == e_done) && (beat == 3'(e_beat)) &&
             (!e_rv || !ref_known[wi] || rdata == e_data) && (e_rv || rdata == 32'd0);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s j=%0d: got ready=%b busy=%b rvalid=%b done=%b beat=%0d rdata=%h, want ready=%b busy=%b rvalid=%b done=%b beat=%0d rdata=%h",
                     tag, j, req_ready, busy, rvalid, done, beat, rdata,
                     !e_busy, e_busy, e_rv, e_done, e_beat, e_data);
        end
    endtask

    task automatic run_req(input string tag, input bit w, input logic [31:0] a, input logic [31:0] d,
                           output logic [2:0] first_beat, output logic [31:0] first_data);
        int waited = 0;
        int n;
        first_beat = '0;
        first_data = '0;
        n = w ? L + 1 : L + 8;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL %s ready timeout: got ready=%b want 1", tag, req_ready);
            return;
        end
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        if (w) begin
            ref_mem[widx(a)]   = d;
            ref_known[widx(a)] = 1'b1;
        end
        for (int j = 0; j <= n; j++) begin
            @(negedge clk);
            check_cycle(tag, w, j, a);
            if (j == L && !w) begin
                first_beat = beat;
                first_data = rdata;
            end
            // junk on the request inputs while busy must be ignored
            if (j == n) begin
                req_valid = 1'b0;
            end else begin
                req_valid = 1'($urandom);
                req_write = 1'($urandom);
                req_addr  = $urandom;
                req_wdata = $urandom;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 8; k++)
            vecs[k] = '{1'b1, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k), 3'd0, 32'd0};
        vecs[8]  = '{1'b0, 32'h0000_0100, 32'd0,         3'd0, 32'h0000_00A0};
        vecs[9]  = '{1'b0, 32'h0000_0114, 32'd0,         3'd5, 32'h0000_00A5};
        vecs[10] = '{1'b0, 32'h0000_011F, 32'd0,         3'd7, 32'h0000_00A7};
        vecs[11] = '{1'b1, 32'h0000_0104, 32'h0000_00C1, 3'd0, 32'd0};
        vecs[12] = '{1'b0, 32'h0000_0104, 32'd0,         3'd1, 32'h0000_00C1};
        vecs[13] = '{1'b1, 32'h0000_1008, 32'h5A5A_5A5A, 3'd0, 32'd0};
        vecs[14] = '{1'b0, 32'h0000_0008, 32'd0,         3'd2, 32'h5A5A_5A5A};

        repeat (3) @(negedge clk);
        check_cycle("reset", 1'b0, L + 8, 32'd0);
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_cycle("idle_hold", 1'b0, L + 8, 32'd0);
        end

        for (int i = 0; i < 15; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].w, vecs[i].addr, vecs[i].data, fb, fd);
            if (!vecs[i].w) begin
                total++;
                if (fb !== vecs[i].exp_beat || fd !== vecs[i].exp_data) begin
                    bad++;
                    $display("FAIL vec%0d first beat: got beat=%0d data=%h want beat=%0d data=%h",
                             i, fb, fd, vecs[i].exp_beat, vecs[i].exp_data);
                end
            end
        end

        for (int k = 0; k < 8; k++)
            run_req("bp_fill", 1'b1, 32'h200 + 32'(4 * k), 32'hB0 + 32'(k), fb, fd);

        // backpressure: second read held valid for the whole first burst
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h100;
        @(posedge clk);
        accepts = 0;
        acc_j = -1;
        busy_low = 0;
        for (int j = 0; j <= 2 * L + 17; j++) begin
            @(negedge clk);
            if (j <= L + 8) check_cycle("bp_first", 1'b0, j, 32'h100);
            else            check_cycle("bp_second", 1'b0, j - (L + 9), 32'h200);
            if (!busy && j < 2 * L + 17) busy_low++;
            if (j <= L + 8 && req_ready && req_valid) begin
                accepts++;
                acc_j = j;
            end
            if (j == 0) req_addr = 32'h200;
            if (j == L + 9) req_valid = 1'b0;
        end
        total++;
        if (accepts != 1 || acc_j != L + 8) begin
            bad++;
            $display("FAIL bp_accepts: got count=%0d at j=%0d want count=1 at j=%0d", accepts, acc_j, L + 8);
        end
        total++;
        if (busy_low != 1) begin
            bad++;
            $display("FAIL bp_busy_gap: got %0d idle cycles want 1", busy_low);
        end

        // reset during the third beat of a burst
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h100;
        @(posedge clk);
        for (int j = 0; j <= L + 2; j++) begin
            @(negedge clk);
            req_valid = 1'b0;
            check_cycle("rst_burst_pre", 1'b0, j, 32'h100);
        end
        rst = 1'b0;
        #1;
        check_cycle("rst_burst_async", 1'b0, L + 8, 32'd0);
        @(negedge clk);
        check_cycle("rst_burst_held", 1'b0, L + 8, 32'd0);
        rst = 1'b1;
        run_req("rst_burst_after", 1'b0, 32'h114, 32'd0, fb, fd);
        total++;
        if (fb !== 3'd5 || fd !== 32'hA5) begin
            bad++;
            $display("FAIL rst_burst_after_data: got beat=%0d data=%h want beat=5 data=000000a5", fb, fd);
        end

        // reset before a write's done: the store must still be visible
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h300;
        req_wdata = 32'h600D_F00D;
        @(posedge clk);
        ref_mem[widx(32'h300)]   = 32'h600D_F00D;
        ref_known[widx(32'h300)] = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check_cycle("rst_write_pre", 1'b1, 0, 32'h300);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_cycle("rst_write_async", 1'b0, L + 8, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_req("rst_write_read", 1'b0, 32'h300, 32'd0, fb, fd);
        total++;
        if (fb !== 3'd0 || fd !== 32'h600D_F00D) begin
            bad++;
            $display("FAIL rst_write_data: got beat=%0d data=%h want beat=0 data=600df00d", fb, fd);
        end

        for (int k = 0; k < 64; k++)
            run_req("rand_fill", 1'b1, 32'h400 + 32'(4 * k), $urandom, fb, fd);
        for (int k = 0; k < 40; k++)
            run_req($sformatf("rand%0d", k), 1'($urandom),
                    ($urandom & 32'hFFFF_F000) | 32'h400 | ($urandom & 32'hFF), $urandom, fb, fd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
